// File: rtl/jtag_debug_cmd_sysclk.sv
// System-clock side of the JTAG debug path: synchronises update-DR/IR strobes,
// queues each update as a command and hands it to the OCI logic via valid/ready.
module jtag_debug_cmd_sysclk #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [SR_W-1:0]               sr,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_is_ir,
  output logic [IR_W-1:0]               cmd_ir,
  output logic [SR_W-1:0]               jdo,
  output logic [2**IR_W-1:0]            action_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int NA = 2**IR_W;

  typedef struct packed {
    logic            is_ir;
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } cmd_t;

  logic [SYNC_STAGES-1:0] r_udr_sync, r_uir_sync, r_fill;
  logic                   r_udr_prev, r_uir_prev, r_udr_armed, r_uir_armed;
  logic                   r_pend;
  cmd_t                   r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr, r_rd;
  logic [LW-1:0]          r_level;
  logic                   r_ovf;
  logic [NA-1:0]          r_pulse;

  logic                   w_udr_lvl, w_uir_lvl, w_udr_ev, w_uir_ev;
  logic                   w_push, w_pend_nxt, w_ir_drop;
  logic                   w_full, w_pop, w_wr;
  cmd_t                   w_entry, w_head;
  logic [NA-1:0]          w_onehot;

  // r_fill marks when the sync chain holds real samples, so reset zeros
  // flowing out of the chain are never mistaken for a low strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_udr_sync  <= '0;
      r_uir_sync  <= '0;
      r_fill      <= '0;
      r_udr_prev  <= 1'b0;
      r_uir_prev  <= 1'b0;
      r_udr_armed <= 1'b0;
      r_uir_armed <= 1'b0;
    end else begin
      r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_udr_prev  <= w_udr_lvl;
      r_uir_prev  <= w_uir_lvl;
      r_udr_armed <= r_udr_armed | (r_fill[SYNC_STAGES-1] & ~w_udr_lvl);
      r_uir_armed <= r_uir_armed | (r_fill[SYNC_STAGES-1] & ~w_uir_lvl);
    end
  end

  assign w_udr_lvl = r_udr_sync[SYNC_STAGES-1];
  assign w_uir_lvl = r_uir_sync[SYNC_STAGES-1];
  assign w_udr_ev  = w_udr_lvl & ~r_udr_prev & r_udr_armed;
  assign w_uir_ev  = w_uir_lvl & ~r_uir_prev & r_uir_armed;

  // DR wins a collision; the IR update waits one cycle in r_pend.
  always_comb begin
    w_push        = 1'b0;
    w_entry       = '0;
    w_pend_nxt    = r_pend;
    w_ir_drop     = 1'b0;
    if (w_udr_ev) begin
      w_push        = 1'b1;
      w_entry.is_ir = 1'b0;
      w_entry.ir    = ir_in;
      w_entry.data  = sr;
      w_pend_nxt    = r_pend | w_uir_ev;
      w_ir_drop     = w_uir_ev & r_pend;
    end else if (r_pend || w_uir_ev) begin
      w_push        = 1'b1;
      w_entry.is_ir = 1'b1;
      w_entry.ir    = ir_in;
      w_pend_nxt    = 1'b0;
      w_ir_drop     = w_uir_ev & r_pend;
    end
  end

  assign w_head    = r_mem[r_rd];
  assign cmd_valid = (r_level != '0);
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_pop     = cmd_valid & cmd_ready;
  assign w_wr      = w_push & (~w_full | w_pop);

  assign cmd_is_ir = cmd_valid & w_head.is_ir;
  assign cmd_ir    = cmd_valid ? w_head.ir   : '0;
  assign jdo       = cmd_valid ? w_head.data : '0;

  always_comb begin
    w_onehot = '0;
    if (w_pop && !w_head.is_ir) w_onehot[w_head.ir] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_wr) r_mem[r_wr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend  <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_pulse <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_pulse <= w_onehot;
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if ((w_push && !w_wr) || w_ir_drop) r_ovf <= 1'b1;
      else if (ovf_clr)                   r_ovf <= 1'b0;
    end
  end

  assign action_pulse = r_pulse;
  assign fifo_level   = r_level;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk.sv
// Directed + randomized bench; a queue-based model tracks expected FIFO contents.
module tb_jtag_debug_cmd_sysclk;
  localparam int IR_W = 2;
  localparam int SR_W = 38;
  localparam int SYNC = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vs_udr = 1'b0, vs_uir = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            cmd_valid, cmd_ready = 1'b0, cmd_is_ir;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] jdo;
  logic [3:0]      action_pulse;
  logic [2:0]      fifo_level;
  logic            overflow, ovf_clr = 1'b0;

  jtag_debug_cmd_sysclk #(.IR_W(IR_W), .SR_W(SR_W), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_ir(cmd_is_ir), .cmd_ir(cmd_ir),
    .jdo(jdo), .action_pulse(action_pulse), .fifo_level(fifo_level), .overflow(overflow),
    .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  typedef struct { bit is_ir; logic [IR_W-1:0] ir; logic [SR_W-1:0] data; } ent_t;
  typedef struct { int at; ent_t e; } ev_t;

  ent_t q[$];
  ev_t  sched[$];
  int   edge_n = 0, tests = 0, fails = 0;
  bit   exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the head, apply the edge to the model, clock, then check registered outputs.
  task automatic step();
    int         e = edge_n + 1;
    bit         popping = 1'b0, set = 1'b0;
    logic [3:0] nxt = '0;
    chk("cmd_valid", 64'(cmd_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_kind", 64'(cmd_is_ir), 64'(q[0].is_ir));
      chk("head_ir",   64'(cmd_ir),    64'(q[0].ir));
      chk("head_jdo",  64'(jdo),       64'(q[0].data));
    end
    if (!reset_n) begin
      q.delete(); sched.delete(); exp_ovf = 1'b0;
    end else begin
      popping = (q.size() != 0) && cmd_ready;
      if (popping && !q[0].is_ir) nxt = 4'b0001 << q[0].ir;
      while (sched.size() != 0 && sched[0].at == e) begin
        if (q.size() == DEPTH && !popping) set = 1'b1;
        else q.push_back(sched[0].e);
        void'(sched.pop_front());
      end
      if (popping) void'(q.pop_front());
      exp_ovf = set ? 1'b1 : (ovf_clr ? 1'b0 : exp_ovf);
    end
    @(posedge clk);
    edge_n = e;
    #1;
    chk("action_pulse", 64'(action_pulse), 64'(nxt));
    chk("overflow",     64'(overflow),     64'(exp_ovf));
    chk("fifo_level",   64'(fifo_level),   64'(q.size()));
  endtask

  // Strobe high 4 cycles then low 4; update lands SYNC edges after the first sampling edge.
  task automatic jev(input bit dr, input bit ir, input logic [IR_W-1:0] irv,
                     input logic [SR_W-1:0] d, input bit rnd_ready);
    int base = edge_n + 1 + SYNC;
    ir_in = irv; sr = d; vs_udr = dr; vs_uir = ir;
    if (dr) sched.push_back('{base, '{1'b0, irv, d}});
    if (ir) sched.push_back('{dr ? base + 1 : base, '{1'b1, irv, '0}});
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin vs_udr = 1'b0; vs_uir = 1'b0; end
      if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  function automatic logic [SR_W-1:0] rsr();
    return SR_W'({$urandom(), $urandom()});
  endfunction

  initial begin
    @(posedge clk); #1;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // single DR update, then accept it
    jev(1'b1, 1'b0, 2'd2, 38'h2A_5555_AAAA, 1'b0);
    cmd_ready = 1'b1;
    repeat (2) step();

    // burst of 6 into a 4-deep queue, drain, clear overflow
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) jev(1'b1, 1'b0, 2'($urandom_range(0, 3)), rsr(), 1'b0);
    cmd_ready = 1'b1;
    repeat (6) step();
    cmd_ready = 1'b0; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();

    // simultaneous DR and IR updates
    jev(1'b1, 1'b1, 2'd1, rsr(), 1'b0);
    cmd_ready = 1'b1;
    repeat (3) step();

    // full queue with push and pop on the same edge
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) jev(1'b1, 1'b0, 2'($urandom_range(0, 3)), rsr(), 1'b0);
    ir_in = 2'd3; sr = rsr(); vs_udr = 1'b1;
    sched.push_back('{edge_n + 1 + SYNC, '{1'b0, 2'd3, sr}});
    repeat (SYNC) step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    vs_udr = 1'b0;
    repeat (4) step();
    cmd_ready = 1'b1;
    repeat (6) step();

    // strobe held high through reset release must not create a command
    cmd_ready = 1'b0; reset_n = 1'b0; vs_udr = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (8) step();
    vs_udr = 1'b0;
    repeat (4) step();
    jev(1'b1, 1'b0, 2'd0, rsr(), 1'b0);
    cmd_ready = 1'b1;
    repeat (2) step();

    // reset with three entries queued
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) jev(1'b1, 1'b0, 2'($urandom_range(0, 3)), rsr(), 1'b0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (4) step();

    // randomized updates with a randomly stalling consumer
    for (int i = 0; i < 30; i++) begin
      int k = int'($urandom_range(0, 2));
      jev(k != 1, k != 0, 2'($urandom_range(0, 3)), rsr(), 1'b1);
    end
    cmd_ready = 1'b1;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
